i2s_speaker_tx: RTL
===================

I2S_SPEAKER_TX -- requirements
Module: i2s_speaker_tx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 18: sample width, two's complement.
REQ-002 SHALL have parameter SLOT_BITS, default 32: BCLK periods per channel slot; SLOT_BITS >= DATA_BITS+1.
REQ-003 SHALL have parameter CLK_DIV, default 2: clk cycles per BCLK period; even, >= 2.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: stereo-pair FIFO entries; power of 2.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
- clk  input  1  system clock, all state on posedge.
- reset  input  1  asynchronous, active-low reset.
- left_in  input  DATA_BITS  left-channel sample.
- right_in  input  DATA_BITS  right-channel sample.
- in_valid  input  1  left_in/right_in pair valid.
- in_ready  output  1  FIFO can accept a pair.
- BCLK  output  1  I2S bit clock.
- LRCLK  output  1  word select; 0 = left, 1 = right.
- DOUT  output  1  serial data, MSB first.
- frame_start  output  1  one-clk pulse when a left slot begins.
- underflow  output  1  one-clk pulse when a frame starts with the FIFO empty.

Function
REQ-006 SHALL push {left_in,right_in} into the FIFO on any clk edge where in_valid && in_ready.
REQ-007 SHALL drive in_ready = (FIFO count < FIFO_DEPTH) as a registered count compare; no combinational path from in_valid.
REQ-008 SHALL generate BCLK by dividing clk: high for CLK_DIV/2 clk cycles, then low for CLK_DIV/2 cycles, repeating.
REQ-009 SHALL update LRCLK and DOUT only in the clk cycle where BCLK goes 1->0 (the "fall event"), so that a receiver samples them stably on BCLK rise.
REQ-010 SHALL keep a slot bit counter 0..SLOT_BITS-1, advanced at each fall event, wrapping from SLOT_BITS-1 to 0 and toggling LRCLK at the wrap.
REQ-011 SHALL drive DOUT = 0 at slot bit 0, which gives the standard I2S one-bit delay after the LRCLK edge.
REQ-012 SHALL drive sample bit DATA_BITS-k on DOUT at slot bits k = 1..DATA_BITS, and 0 for slot bits DATA_BITS+1..SLOT_BITS-1.
REQ-013 At the fall event where LRCLK goes 1->0 (left slot, bit 0), SHALL pop one FIFO pair into the left/right shift registers and pulse frame_start for that clk.
REQ-014 If the FIFO is empty at that pop event, SHALL load zeros into both shift registers, pulse underflow together with frame_start, and leave the FIFO count at 0.
REQ-015 SHALL serialize the right sample in the right slot from the same popped pair; no FIFO access at the right-slot start.
REQ-016 Push and pop in the same clk SHALL leave the count unchanged and both operations SHALL take effect.
REQ-017 A push into an empty FIFO in the pop clk SHALL NOT be bypassed: that frame underflows and the pushed pair plays in the next frame.
REQ-018 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL never exceed FIFO_DEPTH or go below 0.

Reset
REQ-019 Asserting reset SHALL immediately force the following outputs: BCLK=1, LRCLK=1, DOUT=0, frame_start=0, underflow=0, in_ready=1.
REQ-020 On reset assertion, FIFO count and pointers SHALL clear, shift registers SHALL clear, the divider SHALL clear, and the slot counter SHALL be set to SLOT_BITS-1.
REQ-021 Consequence of REQ-020: the first fall event after reset release SHALL start a left slot (LRCLK 1->0, pop, frame_start).
REQ-022 Reset asserted mid-frame SHALL abort the frame with no partial word completion; contents of any pending FIFO entries SHALL be discarded.

Verification
REQ-023 Defaults, push left=18'h2AAAA, right=18'h15555 before release -> first left slot DOUT bits 1..18 = 101010101010101010, bits 19..31 = 0; right slot bits 1..18 = 010101010101010101.
REQ-024 Defaults, no push after reset -> at first left slot frame_start=1 and underflow=1 in the same clk; DOUT=0 for the whole 64-bit frame.
REQ-025 Push 5 pairs back-to-back with in_valid held high -> in_ready drops after the 4th push; the 5th pair is accepted after the first frame_start pop; output order matches push order.
REQ-026 CLK_DIV=4 -> BCLK is 2 clk high, 2 clk low; LRCLK toggles every 128 clk; DOUT/LRCLK change only on BCLK falling edges.
REQ-027 Assert reset at slot bit 10 of a right slot with 2 pairs queued -> outputs take REQ-019 values immediately; after release, underflow pulses at the first frame.
REQ-028 Pair pushed into an empty FIFO in the exact pop clk -> underflow that frame; pair heard in the next frame; count returns to 0.

Source files
------------

// File: rtl/i2s_speaker_tx.sv
// i2s_speaker_tx: stereo-pair FIFO feeding an I2S transmitter with divided bit clock
module i2s_speaker_tx #(
  parameter int DATA_BITS  = 18,
  parameter int SLOT_BITS  = 32,
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] left_in,
  input  logic [DATA_BITS-1:0] right_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 BCLK,
  output logic                 LRCLK,
  output logic                 DOUT,
  output logic                 frame_start,
  output logic                 underflow
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(SLOT_BITS);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [DW-1:0] div, div_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [2*DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_n;
  logic [DATA_BITS-1:0] sr, right_hold;
  logic fall, wrap, frame_pop, push, pop, data_bit;
  always_comb begin
    div_n     = div == DW'(CLK_DIV - 1) ? '0 : div + 1'b1;
    fall      = div == DW'(CLK_DIV/2 - 1);
    wrap      = bit_cnt == BW'(SLOT_BITS - 1);
    bit_n     = wrap ? '0 : bit_cnt + 1'b1;
    frame_pop = fall && wrap && LRCLK;
    push      = in_valid && in_ready;
    pop       = frame_pop && count != '0;
    count_n   = count + CW'(push) - CW'(pop);
    data_bit  = bit_n != '0 && bit_n <= BW'(DATA_BITS);
  end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {left_in, right_in};
  // the active slot shifts out of sr; the right sample waits in right_hold
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      div         <= '0;
      BCLK        <= 1'b1;
      LRCLK       <= 1'b1;
      DOUT        <= 1'b0;
      bit_cnt     <= BW'(SLOT_BITS - 1);
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      in_ready    <= 1'b1;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      sr          <= '0;
      right_hold  <= '0;
    end else begin
      div         <= div_n;
      BCLK        <= div_n < DW'(CLK_DIV/2);
      frame_start <= frame_pop;
      underflow   <= frame_pop && count == '0;
      count       <= count_n;
      in_ready    <= count_n < CW'(FIFO_DEPTH);
      if (push) wptr <= wptr == PW'(FIFO_DEPTH - 1) ? '0 : wptr + 1'b1;
      if (pop) rptr <= rptr == PW'(FIFO_DEPTH - 1) ? '0 : rptr + 1'b1;
      if (fall) begin
        bit_cnt <= bit_n;
        if (wrap) LRCLK <= ~LRCLK;
        DOUT <= data_bit && sr[DATA_BITS-1];
        if (frame_pop) {sr, right_hold} <= pop ? mem[rptr] : '0;
        else if (wrap) sr <= right_hold;
        else if (data_bit) sr <= sr << 1;
      end
    end
endmodule
